// File: rtl/clkdiv_ctrl_pkg.sv
// clkdiv_ctrl shared types and constants
// state encoding, default divide width, reset levels
package clkdiv_ctrl_pkg;

  localparam int DIVW_DEF = 4;

  localparam logic Z_RST  = 1'b0;
  localparam logic ZN_RST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOPPING
  } state_t;

endpackage

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: glitch-free 50% clock divider
// run/stop at phase edges, REQ/ACK ratio load
module clkdiv_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int DIVW = DIVW_DEF
) (
  input  logic            CLK,
  input  logic            RN,
  inout  wire             VDD,
  inout  wire             VSS,
  input  logic            EN,
  input  logic [DIVW-1:0] DIV,
  input  logic            REQ,
  output logic            ACK,
  output logic            Z,
  output logic            ZN,
  output logic            RUN
);

  localparam logic [DIVW-1:0] ONE = DIVW'(1);

  wire unused_supply = VDD ^ VSS;

  state_t          state, state_n;
  logic [DIVW-1:0] cnt, cnt_n;
  logic [DIVW-1:0] div_q, div_n;
  logic            z, z_n;
  logic            zn;
  logic            ack, ack_n;
  logic            tick;
  logic            pend;

  assign tick = (cnt == div_q);
  assign pend = REQ && !ack;

  // register group: FSM, counter, ratio, outputs
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      div_q <= '0;
      z     <= Z_RST;
      zn    <= ZN_RST;
      ack   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      div_q <= div_n;
      z     <= z_n;
      zn    <= ~z_n;
      ack   <= ack_n;
    end
  end

  // next state: toggle at T, stop only at boundaries, load on Z fall
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_q;
    z_n     = z;
    ack_n   = ack;
    if (ack && !REQ) ack_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        z_n   = 1'b0;
        if (pend) begin
          div_n = DIV;
          ack_n = 1'b1;
        end
        if (EN) begin
          state_n = ST_RUN;
          z_n     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!EN && !z) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (tick) begin
          cnt_n = '0;
          z_n   = ~z;
          if (z && pend) begin
            div_n = DIV;
            ack_n = 1'b1;
          end
          if (!EN) state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + ONE;
          if (!EN) state_n = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (tick) begin
          cnt_n   = '0;
          z_n     = 1'b0;
          state_n = ST_IDLE;
          if (pend) begin
            div_n = DIV;
            ack_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        z_n     = 1'b0;
      end
    endcase
  end

  assign Z   = z;
  assign ZN  = zn;
  assign ACK = ack;
  assign RUN = (state != ST_IDLE);

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// clkdiv_ctrl bench: directed scenarios plus random
// EN/REQ traffic against a phase-length model
module tb_clkdiv_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rn;
  logic         en;
  logic [W-1:0] div;
  logic         req;
  logic         ack, z, zn, run;
  wire          vdd;
  wire          vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // model: mode 0=idle 1=run 2=stopping; left = cycles left in phase
  int m_mode, m_left, m_ratio;
  bit m_z, m_ack;

  clkdiv_ctrl #(.DIVW(W)) dut (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss),
    .EN(en), .DIV(div), .REQ(req),
    .ACK(ack), .Z(z), .ZN(zn), .RUN(run)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_ratio = 0; m_z = 0; m_ack = 0;
  endtask

  task automatic m_edge();
    bit pend, fall;
    pend = req && !m_ack;
    if (m_ack && !req) m_ack = 0;
    fall = 0;
    case (m_mode)
      0: begin
        if (pend) begin m_ratio = int'(div); m_ack = 1; end
        if (en) begin m_mode = 1; m_z = 1; m_left = m_ratio + 1; end
      end
      1: begin
        if (!en && !m_z) m_mode = 0;
        else if (m_left == 1) begin
          fall = m_z;
          if (fall && pend) begin m_ratio = int'(div); m_ack = 1; end
          m_z = !m_z;
          m_left = m_ratio + 1;
          if (!en) m_mode = 0;
        end else begin
          m_left--;
          if (!en) m_mode = 2;
        end
      end
      default: begin
        if (m_left == 1) begin
          if (pend) begin m_ratio = int'(div); m_ack = 1; end
          m_z = 0;
          m_mode = 0;
        end else m_left--;
      end
    endcase
  endtask

  task automatic cmp_all(string tag);
    check({tag, ".z"}, 32'(z), 32'(m_z));
    check({tag, ".zn"}, 32'(zn), 32'(!m_z));
    check({tag, ".ack"}, 32'(ack), 32'(m_ack));
    check({tag, ".run"}, 32'(run), 32'(m_mode != 0));
  endtask

  task automatic tick(string tag, int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rn) m_edge();
      #1;
      cmp_all(tag);
    end
  endtask

  initial begin
    int hi;
    rn = 1'b0; en = 1'b0; div = '0; req = 1'b0;
    m_reset();
    #12;
    cmp_all("reset");
    rn = 1'b1;
    tick("idle", 2);

    // default ratio: divide-by-2
    en = 1'b1;
    tick("div2", 8);
    en = 1'b0;
    tick("div2stop", 3);

    // load in idle, then start
    req = 1'b1; div = 4'd2;
    tick("ld_idle");
    check("ack_1cyc", 32'(ack), 32'd1);
    req = 1'b0;
    tick("ack_drop");
    check("ack_low", 32'(ack), 32'd0);
    en = 1'b1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick("div3");
      if (i < 3) hi += int'(z);
    end
    check("hi3", 32'(hi), 32'd3);

    // run at DIV=3, then request DIV=0 mid-high
    en = 1'b0;
    tick("stop", 4);
    req = 1'b1; div = 4'd3;
    tick("ld3", 2);
    req = 1'b0;
    tick("ld3b");
    en = 1'b1;
    tick("run4", 2);
    req = 1'b1; div = 4'd0;
    tick("midreq", 12);
    req = 1'b0;
    tick("midrel", 3);

    // stop during high phase at DIV=3
    en = 1'b0;
    tick("stop0", 3);
    req = 1'b1; div = 4'd3;
    tick("ld3c");
    req = 1'b0;
    en = 1'b1;
    tick("hi_start", 2);
    en = 1'b0;
    tick("stop_hi", 6);
    check("stop_hi_z", 32'(z), 32'd0);

    // stop during low phase
    en = 1'b1;
    tick("restart", 5);
    en = 1'b0;
    tick("stop_lo", 2);
    en = 1'b1;
    tick("start_lo");
    check("start_z", 32'(z), 32'd1);

    // async reset mid-high at DIV=5
    en = 1'b0;
    tick("pre5", 6);
    req = 1'b1; div = 4'd5;
    tick("ld5");
    en = 1'b1;
    tick("run5", 2);
    rn = 1'b0; req = 1'b0;
    #1;
    m_reset();
    cmp_all("arst");
    tick("arst_hold");
    rn = 1'b1;
    tick("post_rst", 6);

    // random traffic with legal four-phase handshake
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      if (!req && !m_ack && $urandom_range(0, 15) == 0) begin
        div = W'($urandom_range(0, 15));
        req = 1'b1;
      end else if (req && m_ack && $urandom_range(0, 2) == 0) begin
        req = 1'b0;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Programmable, glitch-free clock divider and run/stop controller for the mcu9t5v0 clock-tree library. It sits upstream of the clkinv and clkbuf cells. It turns the source clock CLK into a 50%-duty divided clock with a complementary output pair. Start and stop always happen at phase boundaries. Ratio changes go through a four-phase REQ/ACK handshake, so downstream logic never sees a runt pulse.

## Interface
- DIVW, 4, width of the divide field; output period = 2*(DIV+1) CLK cycles
- CLK  input  1  source clock; all state updates on the rising edge
- RN  input  1  asynchronous, active-low reset
- VDD  inout  1  supply; no logic function
- VSS  inout  1  ground; no logic function
- EN  input  1  run request; level-sensitive
- DIV  input  DIVW  half-period minus one; sampled only on load; stable while REQ=1
- REQ  input  1  ratio-load request; four-phase
- ACK  output  1  ratio-load acknowledge
- Z  output  1  divided clock, registered
- ZN  output  1  complement of Z, separately registered (same edge as Z)
- RUN  output  1  high while in RUN or STOPPING

## Operation
- Reset (RN=0, asynchronous):
  - Z=0, ZN=1, ACK=0, RUN=0.
  - state=IDLE, cnt=0, div_q=0, so the default ratio is divide-by-2.
- Internal registers: state in {IDLE, RUN, STOPPING}; cnt[DIVW-1:0]; div_q[DIVW-1:0].
- Toggle point: T = (cnt==div_q).
  - At T, Z and ZN invert and cnt returns to 0.
  - Otherwise cnt increments by 1.
  - No wrap is possible, because cnt never exceeds div_q.
- IDLE:
  - Z=0, cnt=0.
  - EN=1 sampled → RUN, with Z=1, ZN=0 and cnt=0 on that same edge.
- RUN:
  - Z toggles at T.
  - EN=0 sampled while Z=0 → IDLE immediately; Z stays 0 and cnt=0.
  - EN=0 sampled while Z=1 → STOPPING.
- STOPPING:
  - Counting continues. At T (the falling boundary), Z goes to 0 and the state goes to IDLE.
  - EN returning to 1 in STOPPING is ignored until IDLE is reached.
  - The high phase is never truncated.
- Handshake (REQ/ACK):
  - REQ=1 with ACK=0 makes a load pending.
  - In IDLE the load happens on the next edge: div_q←DIV, ACK←1.
  - In RUN or STOPPING the load happens only on an edge where T and Z=1, i.e. Z falling.
  - The new ratio applies from the next low phase onward.
  - ACK stays high until REQ=0 is sampled, then drops on that edge.
  - REQ=1 while ACK=1 does not reload.
- Simultaneous events:
  - A pending load and a STOPPING→IDLE transition on the same falling edge both take effect.
  - EN rising in IDLE with REQ pending: the load and the start happen on the same edge, and the new div_q governs the first high phase.

## Timing
- All outputs are registered. There is no combinational path from inputs to Z, ZN, ACK or RUN.
- EN sampled high in IDLE at edge n → Z=1 after edge n.
- The high phase lasts div_q+1 cycles and the low phase lasts div_q+1 cycles.
- Ratio-change latency in RUN: 0 to 2*(div_q+1) cycles, until the next Z falling edge. In IDLE the latency is 1 cycle.
- ACK deassert latency: 1 cycle after REQ=0 is sampled.
- Reset mid-operation:
  - Z=0 and ZN=1 immediately.
  - A partial high pulse is accepted, since reset is system-wide.
  - div_q returns to 0.

## Structure
- Shared package holds:
  - the state enum typedef (IDLE, RUN, STOPPING);
  - the DIVW default constant;
  - reset-value constants for Z and ZN.
- Single module; no sub-module is warranted.
- Counter, FSM and handshake share the T term and must stay in one always block per register group.

## Test plan
- Default ratio after reset:
  - Stimulus: reset, then EN=1 held.
  - Required: Z toggles every cycle (period 2); ZN is always the complement of Z; RUN=1.
- Load in IDLE, then start:
  - Stimulus: REQ=1 with DIV=2, then EN=1.
  - Required: ACK=1 one cycle after REQ; Z high 3 cycles, low 3 cycles.
- Ratio change mid-run:
  - Stimulus: REQ with DIV=0 while running at DIV=3, asserted mid high phase.
  - Required: ACK rises on the Z falling edge; the next low phase is 1 cycle; the old high phase stays 4 cycles.
- Stop during high phase:
  - Stimulus: EN=0 on cycle 1 of a 4-cycle high phase.
  - Required: Z stays high the full 4 cycles, then 0; RUN drops with it; state is IDLE.
- Stop during low phase:
  - Stimulus: EN=0 during a low phase.
  - Required: Z remains 0; IDLE is entered on the next edge; a later EN=1 produces Z=1 one edge later.
- Asynchronous reset mid-high phase:
  - Stimulus: RN=0 while Z=1 at DIV=5.
  - Required: Z=0, ZN=1 and ACK=0 without a CLK edge; div_q is back to 0, confirmed by a divide-by-2 restart.
